// File: rtl/otter_wb_pkg.sv
// Shared writeback definitions for the register-file write arbiter.
//
// Contents:
//   REG_ADDR_W          - register-file address width (5)
//   XLEN                - register data width (32)
//   STARVE_MAX_DEFAULT  - default pipeline grants allowed while aux writes wait
//   AUX_ENTRY_W         - width of one buffered auxiliary write {addr, data}
//   wb_state_e          - arbiter states (EMPTY, SHARE, FORCE)
//   wb_write_t          - packed {addr, data} register-file write
package otter_wb_pkg;

  localparam int REG_ADDR_W         = 5;
  localparam int XLEN               = 32;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int AUX_ENTRY_W        = REG_ADDR_W + XLEN;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHARE = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_write_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small circular FIFO holding auxiliary register-file writes until granted.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   push_i         - enqueue wdata_i (ignored when full)
//   wdata_i        - entry to enqueue
//   pop_i          - dequeue the head (ignored when empty)
//   rdata_o        - current head entry (valid while not empty)
//   full_o         - no free slot
//   empty_o        - no stored entry
//   count_o        - registered occupancy
module rf_wr_fifo
  import otter_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = AUX_ENTRY_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage and a buffer
// of long-latency (load/multiply/divide) results. One write is granted per
// cycle and registered onto RF_WE/RF_WA/RF_WD. The pipeline normally has
// priority, but after STARVE_MAX consecutive pipeline grants with buffered
// writes waiting, the buffer head is forced through and the pipeline stalls.
//
// Ports:
//   CLK, RST_N                       - clock, asynchronous active-low reset
//   PIPE_VALID/PIPE_ADDR/PIPE_DATA   - writeback stage write request
//   PIPE_STALL                       - pipeline write not granted this cycle
//   AUX_VALID/AUX_ADDR/AUX_DATA      - auxiliary write offer
//   AUX_READY                        - buffer not full
//   AUX_CNT                          - buffer occupancy
//   RF_WE/RF_WA/RF_WD                - registered register-file write port
module rf_write_arbiter
  import otter_wb_pkg::*;
#(
  parameter int AUX_DEPTH  = 2,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PIPE_VALID,
  input  logic [REG_ADDR_W-1:0]    PIPE_ADDR,
  input  logic [XLEN-1:0]          PIPE_DATA,
  output logic                     PIPE_STALL,
  input  logic                     AUX_VALID,
  output logic                     AUX_READY,
  input  logic [REG_ADDR_W-1:0]    AUX_ADDR,
  input  logic [XLEN-1:0]          AUX_DATA,
  output logic [$clog2(AUX_DEPTH):0] AUX_CNT,
  output logic                     RF_WE,
  output logic [REG_ADDR_W-1:0]    RF_WA,
  output logic [XLEN-1:0]          RF_WD
);

  localparam int CNT_W  = $clog2(AUX_DEPTH) + 1;
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  wb_state_e             state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [XLEN-1:0]       rf_wd_q, rf_wd_d;

  logic                  grant_pipe;
  logic                  grant_aux;
  wb_write_t             head;
  wb_write_t             gnt;

  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  last_entry;

  // Readiness depends only on occupancy, never on a same-cycle dequeue.
  assign AUX_READY  = !fifo_full;
  assign fifo_push  = AUX_VALID && AUX_READY;
  assign last_entry = (fifo_count == CNT_W'(1));

  rf_wr_fifo #(
    .DEPTH (AUX_DEPTH),
    .WIDTH (AUX_ENTRY_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (fifo_push),
    .wdata_i ({AUX_ADDR, AUX_DATA}),
    .pop_i   (grant_aux),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Grant selection and next state. The head seen here was stored on an
  // earlier edge, so a write is never granted in its own transfer cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    PIPE_STALL = 1'b0;
    case (state_q)
      EMPTY: begin
        grant_pipe = PIPE_VALID;
        wait_cnt_d = '0;
        if (fifo_push) begin
          state_d = SHARE;
        end
      end
      SHARE: begin
        if (PIPE_VALID) begin
          grant_pipe = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_W'(STARVE_MAX)) begin
            state_d = FORCE;
          end
        end else begin
          grant_aux  = !fifo_empty;
          wait_cnt_d = '0;
          if (last_entry && !fifo_push) begin
            state_d = EMPTY;
          end
        end
      end
      FORCE: begin
        grant_aux  = !fifo_empty;
        PIPE_STALL = PIPE_VALID;
        wait_cnt_d = '0;
        state_d    = (last_entry && !fifo_push) ? EMPTY : SHARE;
      end
      default: begin
        state_d    = EMPTY;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Granted write payload; writes to x0 are consumed but never committed.
  always_comb begin
    gnt     = grant_aux ? head : wb_write_t'({PIPE_ADDR, PIPE_DATA});
    rf_we_d = (grant_pipe || grant_aux) && (gnt.addr != '0);
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (grant_pipe || grant_aux) begin
      rf_wa_d = gnt.addr;
      rf_wd_d = gnt.data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= EMPTY;
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  assign AUX_CNT = fifo_count;
  assign RF_WE   = rf_we_q;
  assign RF_WA   = rf_wa_q;
  assign RF_WD   = rf_wd_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A behavioural model (queue of
// buffered writes plus a starvation streak counter) decides each cycle's
// grant; committed writes are pushed into a scoreboard queue and a separate
// monitor compares them against RF_WE/RF_WA/RF_WD.
module tb_rf_write_arbiter;

  localparam int AUX_DEPTH  = 2;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = $clog2(AUX_DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             PIPE_VALID = 1'b0;
  logic [4:0]       PIPE_ADDR = '0;
  logic [31:0]      PIPE_DATA = '0;
  logic             PIPE_STALL;
  logic             AUX_VALID = 1'b0;
  logic             AUX_READY;
  logic [4:0]       AUX_ADDR = '0;
  logic [31:0]      AUX_DATA = '0;
  logic [CNT_W-1:0] AUX_CNT;
  logic             RF_WE;
  logic [4:0]       RF_WA;
  logic [31:0]      RF_WD;

  int errors = 0;
  int checks = 0;

  logic [36:0] auxQ[$];
  logic [36:0] expQ[$];
  int          streak = 0;
  bit          forced = 1'b0;

  rf_write_arbiter #(
    .AUX_DEPTH  (AUX_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PIPE_VALID (PIPE_VALID),
    .PIPE_ADDR  (PIPE_ADDR),
    .PIPE_DATA  (PIPE_DATA),
    .PIPE_STALL (PIPE_STALL),
    .AUX_VALID  (AUX_VALID),
    .AUX_READY  (AUX_READY),
    .AUX_ADDR   (AUX_ADDR),
    .AUX_DATA   (AUX_DATA),
    .AUX_CNT    (AUX_CNT),
    .RF_WE      (RF_WE),
    .RF_WA      (RF_WA),
    .RF_WD      (RF_WD)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                               input bit av, input logic [4:0] aa, input logic [31:0] ad,
                               output bit stalled, output bit accepted);
    int          depthNow;
    bit          expReady;
    bit          gp;
    bit          ga;
    bit          es;
    logic [36:0] headEntry;
    PIPE_VALID = pv;
    PIPE_ADDR  = pa;
    PIPE_DATA  = pd;
    AUX_VALID  = av;
    AUX_ADDR   = aa;
    AUX_DATA   = ad;
    depthNow = auxQ.size();
    expReady = (depthNow < AUX_DEPTH);
    gp = 1'b0;
    ga = 1'b0;
    es = 1'b0;
    if (depthNow == 0) begin
      gp = pv;
    end else if (forced) begin
      ga = 1'b1;
      es = pv;
    end else if (pv) begin
      gp = 1'b1;
    end else begin
      ga = 1'b1;
    end
    #1;
    checkOutput("pipe_stall", 64'(PIPE_STALL), 64'(es));
    checkOutput("aux_ready", 64'(AUX_READY), 64'(expReady));
    checkOutput("aux_cnt", 64'(AUX_CNT), 64'(depthNow));
    @(posedge CLK);
    if (gp && pa != 5'd0) expQ.push_back({pa, pd});
    if (ga) begin
      headEntry = auxQ.pop_front();
      if (headEntry[36:32] != 5'd0) expQ.push_back(headEntry);
      streak = 0;
      forced = 1'b0;
    end else if (gp && depthNow > 0) begin
      streak++;
      if (streak == STARVE_MAX) forced = 1'b1;
    end
    if (depthNow == 0) begin
      streak = 0;
      forced = 1'b0;
    end
    if (av && expReady) auxQ.push_back({aa, ad});
    stalled  = es;
    accepted = av && expReady;
    #1;
  endtask

  task automatic idleCycles(input int n);
    bit s;
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s, a);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic resetMidOp();
    #2;
    RST_N      = 1'b0;
    PIPE_VALID = 1'b0;
    AUX_VALID  = 1'b0;
    #1;
    checkOutput("rst_rf_we", 64'(RF_WE), 64'd0);
    checkOutput("rst_rf_wa", 64'(RF_WA), 64'd0);
    checkOutput("rst_rf_wd", 64'(RF_WD), 64'd0);
    checkOutput("rst_aux_cnt", 64'(AUX_CNT), 64'd0);
    checkOutput("rst_aux_ready", 64'(AUX_READY), 64'd1);
    checkOutput("rst_pipe_stall", 64'(PIPE_STALL), 64'd0);
    auxQ.delete();
    expQ.delete();
    streak = 0;
    forced = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every committed write must match the oldest expected one.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge CLK);
      if (RF_WE === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rf_unexpected_write: RF_WE=1 wa=%0d wd=0x%08h, expected no write", RF_WA, RF_WD);
        end else begin
          e = expQ.pop_front();
          checkOutput("rf_wa", 64'(RF_WA), 64'(e[36:32]));
          checkOutput("rf_wd", 64'(RF_WD), 64'(e[31:0]));
        end
      end else if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL rf_missed_write: RF_WE=%b, expected write wa=%0d wd=0x%08h", RF_WE, e[36:32], e[31:0]);
      end
    end
  end

  initial begin
    bit          st;
    bit          acc;
    bit          pv;
    bit          av;
    logic [4:0]  pa;
    logic [4:0]  aa;
    logic [31:0] pd;
    logic [31:0] ad;
    int          stallCount;
    int          firstStall;
    int          sent;

    // Reset state
    #12;
    checkOutput("init_rf_we", 64'(RF_WE), 64'd0);
    checkOutput("init_rf_wa", 64'(RF_WA), 64'd0);
    checkOutput("init_rf_wd", 64'(RF_WD), 64'd0);
    checkOutput("init_aux_cnt", 64'(AUX_CNT), 64'd0);
    checkOutput("init_aux_ready", 64'(AUX_READY), 64'd1);
    checkOutput("init_pipe_stall", 64'(PIPE_STALL), 64'd0);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Pipeline-only write
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, st, acc);
    idleCycles(2);

    // Auxiliary write on an idle pipeline
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, st, acc);
    idleCycles(3);

    // Starvation: one pending aux entry, pipeline always valid
    applyStimulus(1'b1, 5'd3, 32'hA0, 1'b1, 5'd9, 32'h55, st, acc);
    pd = 32'd100;
    stallCount = 0;
    firstStall = -1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'd6, pd, 1'b0, 5'd0, 32'd0, st, acc);
      if (st) begin
        stallCount++;
        if (firstStall < 0) firstStall = i;
      end else begin
        pd++;
      end
    end
    checkOutput("starve_stall_count", 64'(stallCount), 64'd1);
    checkOutput("starve_stall_cycle", 64'(firstStall), 64'(STARVE_MAX));
    idleCycles(2);

    // Full buffer: three back-to-back offers under pipeline pressure
    sent = 0;
    for (int c = 0; c < 40 && sent < 3; c++) begin
      applyStimulus(1'b1, 5'd10, pd, 1'b1, 5'(11 + sent), 32'hA000 + 32'(sent), st, acc);
      if (!st) pd++;
      if (acc) sent++;
    end
    checkOutput("full_offers_accepted", 64'(sent), 64'd3);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 5'd10, pd, 1'b0, 5'd0, 32'd0, st, acc);
      if (!st) pd++;
    end
    idleCycles(3);

    // Writes to x0 on both sources
    applyStimulus(1'b1, 5'd0, 32'hFFFF0000, 1'b1, 5'd0, 32'h0000FFFF, st, acc);
    idleCycles(3);
    checkOutput("x0_aux_cnt_drained", 64'(AUX_CNT), 64'd0);

    // Mid-operation reset with two buffered entries
    applyStimulus(1'b1, 5'd12, 32'h11, 1'b1, 5'd13, 32'h22, st, acc);
    applyStimulus(1'b1, 5'd12, 32'h12, 1'b1, 5'd14, 32'h23, st, acc);
    checkOutput("pre_reset_aux_cnt", 64'(AUX_CNT), 64'd2);
    resetMidOp();
    idleCycles(4);

    // Randomized traffic with holding sources
    st = 1'b0;
    acc = 1'b0;
    pv = 1'b0;
    av = 1'b0;
    pa = '0;
    aa = '0;
    ad = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        pv = ($urandom_range(0, 3) != 0);
        pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pd = $urandom;
      end
      if (!av || acc) begin
        av = ($urandom_range(0, 2) == 0);
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ad = $urandom;
      end
      applyStimulus(pv, pa, pd, av, aa, ad, st, acc);
      if (i == 700) begin
        resetMidOp();
        st = 1'b0;
        av = 1'b0;
        acc = 1'b0;
      end
    end

    // Drain and confirm nothing is left over
    idleCycles(AUX_DEPTH + 4);
    checkOutput("final_aux_cnt", 64'(AUX_CNT), 64'd0);
    checkOutput("final_pending_writes", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
